mul_final_stage: RTL and testbench
==================================

Name: mul_final_stage

Overview:
- Final carry-propagate and result stage of the pipelined 33x33 Booth/Wallace multiplier in the EXE path.
- Consumes the per-column sum/carry vectors from the 66 Wallace column slices and registers them.
- Adds them to form the 66-bit product, selects the 32-bit half requested by the instruction, and presents it with a tag to the MEM/WB side under valid/ready handshakes.
- Supports pipeline flush on exception or branch cancel.

Parameters:
- PW, 66, product width (one Wallace column per bit)
- TAG_W, 5, destination-register tag width carried alongside the data

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  upstream has a column vector set
- in_ready  out  1  stage can accept this cycle
- in_s  in  PW  column sum bits; bit i = S of column i
- in_c  in  PW  column carry bits; bit i = C of column i (weight i+1)
- in_cin  in  1  leftover low-order carry injected at bit 0
- in_op  in  2  0=MUL low word, 1=MULH signed high, 2=MULHU unsigned high, 3=reserved
- in_tag  in  TAG_W  destination tag
- flush  in  1  cancel all in-flight operations
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  selected product word
- out_tag  out  TAG_W  tag of out_result

Behaviour:
- Two register stages, each with its own valid bit:
  - S1 holds s, c, cin, op, tag.
  - S2 holds result and tag.
- Arithmetic in S1→S2:
  - prod = in_s + {in_c[PW-2:0], in_cin}, modulo 2^PW.
  - in_c[PW-1] is discarded.
- Result selection by op:
  - op 0 → prod[31:0].
  - op 1 and op 2 → prod[63:32]; the signed/unsigned distinction was already applied upstream via 33-bit operand extension.
  - op 3 → prod[31:0].
- Handshake:
  - s2_adv = !v2 | out_ready.
  - s1_adv = !v1 | s2_adv.
  - in_ready = s1_adv, combinational; there is no combinational path from in_valid to in_ready.
  - Accept when in_valid & in_ready.
  - S1→S2 moves when v1 & s2_adv.
  - Output retires when out_valid & out_ready.
- Latency: accepted in cycle N → out_valid in cycle N+2 if no stall.
- Throughput: 1 result per cycle when out_ready stays high.
- Backpressure:
  - out_valid, out_result and out_tag hold stable while out_valid & !out_ready.
  - S1 holds when S2 is stalled.
  - in_ready drops only when both stages are valid and out_ready=0.
- Flush has priority over everything:
  - The flush cycle clears v1 and v2 at the clock edge.
  - Any input handshaked in the flush cycle is dropped.
  - in_ready is still driven normally during flush.
  - out_valid in the cycle after flush = 0.
- Reset (synchronous, active-high):
  - v1=0, v2=0, out_valid=0, out_result=0, out_tag=0.
  - Data registers in S1 need not be reset.
  - Reset mid-operation discards all in-flight operations.
- Data registers load only on their stage's advance/accept; they never update while stalled.
- A simultaneous retire from S2 and advance from S1 is legal in the same cycle (full throughput).

Decomposition:
- Shared package mul_pkg:
  - MUL_OP_LO=2'd0, MUL_OP_HS=2'd1, MUL_OP_HU=2'd2.
  - PROD_W=66, TAG_W=5.
  - Typedef for the S1 payload struct {s, c, cin, op, tag}.
- One natural combinational sub-module, mul_cpa:
  - Parameterised PW-bit adder a + b + cin.
  - Lets synthesis choose or replace the adder structure.
- Handshake and select logic stay in mul_final_stage.

Test Plan:
- Single op, 3*5: s=0x...0F (bit pattern 15), c=0, cin=0, op=0, tag=7, out_ready=1 → out_valid 2 cycles later, out_result=0x0000000F, out_tag=7.
- Carry weighting: s=0x5, c=0x5, cin=1, op=0 → prod=5+(5<<1)+1=16, out_result=0x00000010.
- High word: s=0x0_FFFFFFFF_FFFFFFFF, c=0, cin=1, op=2 → prod=0x1_00000000_00000000 (PW-bit), out_result=0x00000000; same vectors with op=0 → 0x00000000; s=0x0_12345678_00000000, op=1 → 0x12345678.
- Backpressure: 4 back-to-back ops with out_ready=0 for 3 cycles → in_ready falls after 2 accepts; out_result is stable while stalled; all 4 results emerge in order with correct tags, none lost or duplicated.
- Flush: accept ops A and B, assert flush while A is in S2 and B is in S1, with a concurrent input C accepted → no output for A, B or C; the next op D returns normally with latency 2.
- Reset mid-stream: reset asserted with both stages valid → next cycle out_valid=0, out_result=0, out_tag=0, in_ready=1.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier final stage: op encodings, widths and
// the payload captured from the Wallace tree into the first register stage.
package mul_pkg;

   localparam logic [1:0] MUL_OP_LO = 2'd0;
   localparam logic [1:0] MUL_OP_HS = 2'd1;
   localparam logic [1:0] MUL_OP_HU = 2'd2;

   localparam int PROD_W = 66;
   localparam int TAG_W  = 5;

   // The carry vector's top column has weight 2^PROD_W and is dropped before capture.
   typedef struct packed {
      logic [PROD_W-1:0] s;
      logic [PROD_W-2:0] c;
      logic              cin;
      logic [1:0]        op;
      logic [TAG_W-1:0]  tag;
   } s1_payload_t;

endpackage

// File: rtl/mul_cpa.sv
// Carry-propagate adder a + b + cin, modulo 2^PW. Kept behavioural so synthesis
// is free to pick the adder architecture.
module mul_cpa
   import mul_pkg::*;
#(
   parameter int PW = PROD_W
) (
   input  logic [PW-1:0] a,
   input  logic [PW-1:0] b,
   input  logic          cin,
   output logic [PW-1:0] sum
);

   assign sum = a + b + PW'(cin);

endmodule

// File: rtl/mul_final_stage.sv
// Final stage of the 33x33 multiplier: registers the Wallace sum/carry vectors,
// resolves them to the product, selects the requested word and hands it to MEM/WB.
module mul_final_stage
   import mul_pkg::*;
#(
   parameter int PW    = PROD_W,
   parameter int TAG_W = mul_pkg::TAG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PW-1:0]    in_s,
   input  logic [PW-1:0]    in_c,
   input  logic             in_cin,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag
);

   s1_payload_t      pay_p1_q, pay_p1_d;
   logic             vld_p1_q, vld_p1_d;
   logic             vld_p2_q, vld_p2_d;
   logic [31:0]      res_p2_q, res_p2_d;
   logic [TAG_W-1:0] tag_p2_q, tag_p2_d;

   logic             s1_adv, s2_adv, accept, move_p2;
   logic [PW-1:0]    prod;
   logic [31:0]      sel;
   logic             unused_bits;

   assign s2_adv   = !vld_p2_q | out_ready;
   assign s1_adv   = !vld_p1_q | s2_adv;
   assign in_ready = s1_adv;
   assign accept   = in_valid & s1_adv;
   assign move_p2  = vld_p1_q & s2_adv;

   // p1 -> p2: resolve sum/carry into the product and pick the result word
   mul_cpa #(.PW(PW)) u_cpa (
      .a   (pay_p1_q.s),
      .b   ({pay_p1_q.c, 1'b0}),
      .cin (pay_p1_q.cin),
      .sum (prod)
   );

   // Signedness was folded into the 33-bit operand extension upstream.
   always_comb begin
      case (pay_p1_q.op)
         MUL_OP_HS, MUL_OP_HU: sel = prod[63:32];
         default:              sel = prod[31:0];
      endcase
   end

   assign unused_bits = ^{in_c[PW-1], prod[PW-1:64]};

   always_comb begin
      pay_p1_d = pay_p1_q;
      res_p2_d = res_p2_q;
      tag_p2_d = tag_p2_q;
      if (accept) begin
         pay_p1_d = '{s: in_s, c: in_c[PW-2:0], cin: in_cin, op: in_op, tag: in_tag};
      end
      if (move_p2) begin
         res_p2_d = sel;
         tag_p2_d = pay_p1_q.tag;
      end
      vld_p1_d = accept | (vld_p1_q & !s2_adv);
      vld_p2_d = move_p2 | (vld_p2_q & !out_ready);
      if (flush) begin
         vld_p1_d = 1'b0;
         vld_p2_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         res_p2_q <= '0;
         tag_p2_q <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         res_p2_q <= res_p2_d;
         tag_p2_q <= tag_p2_d;
      end
   end

   always_ff @(posedge clk) begin
      pay_p1_q <= pay_p1_d;
   end

   assign out_valid  = vld_p2_q;
   assign out_result = res_p2_q;
   assign out_tag    = tag_p2_q;

endmodule

// File: tb/tb_mul_final_stage.sv
// Directed bench for mul_final_stage: arithmetic/select vectors, backpressure,
// flush and mid-stream reset, all against hand-computed expectations.
module tb_mul_final_stage;

   localparam int PW = 66;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_s;
   logic [PW-1:0] in_c;
   logic          in_cin;
   logic [1:0]    in_op;
   logic [TW-1:0] in_tag;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_result;
   logic [TW-1:0] out_tag;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mul_final_stage dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_s       (in_s),
      .in_c       (in_c),
      .in_cin     (in_cin),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [PW-1:0] s, input logic [PW-1:0] c, input logic cin,
                        input logic [1:0] op, input logic [TW-1:0] tag);
      in_valid = 1'b1;
      in_s     = s;
      in_c     = c;
      in_cin   = cin;
      in_op    = op;
      in_tag   = tag;
   endtask

   // One isolated op with out_ready high: checks latency and the result word.
   task automatic run_one(input string name, input logic [PW-1:0] s, input logic [PW-1:0] c,
                          input logic cin, input logic [1:0] op, input logic [TW-1:0] tag,
                          input logic [31:0] exp);
      drive(s, c, cin, op, tag);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_lat1"}, 66'(out_valid), 66'd0);
      next_cycle();
      @(negedge clk);
      check({name, "_vld"}, 66'(out_valid), 66'd1);
      check({name, "_res"}, 66'(out_result), 66'(exp));
      check({name, "_tag"}, 66'(out_tag), 66'(tag));
      next_cycle();
   endtask

   logic [PW-1:0] bp_s   [4] = '{66'h11, 66'h22, 66'h33, 66'h44};
   logic [PW-1:0] bp_c   [4] = '{66'h1, 66'h2, 66'h0, 66'h3};
   logic [31:0]   bp_exp [4] = '{32'h13, 32'h26, 32'h33, 32'h4A};
   logic [TW-1:0] bp_tag [4] = '{5'd1, 5'd2, 5'd3, 5'd4};

   logic          mon_en = 1'b0;
   logic [31:0]   got_res[$];
   logic [TW-1:0] got_tag[$];

   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         got_res.push_back(out_result);
         got_tag.push_back(out_tag);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0]   held_res;
      logic [TW-1:0] held_tag;
      int            k;
      int            seen_valid;

      reset = 1'b1; in_valid = 1'b0; in_s = '0; in_c = '0; in_cin = 1'b0;
      in_op = 2'd0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 66'(out_valid), 66'd0);
      check("rst_out_result", 66'(out_result), 66'd0);
      check("rst_out_tag", 66'(out_tag), 66'd0);
      check("rst_in_ready", 66'(in_ready), 66'd1);
      next_cycle();

      run_one("single", 66'hF, 66'h0, 1'b0, 2'd0, 5'd7, 32'h0000000F);
      run_one("carry_wt", 66'h5, 66'h5, 1'b1, 2'd0, 5'd3, 32'h00000010);
      run_one("hi_wrap_hu", 66'h0_FFFF_FFFF_FFFF_FFFF, 66'h0, 1'b1, 2'd2, 5'd9, 32'h0);
      run_one("hi_wrap_lo", 66'h0_FFFF_FFFF_FFFF_FFFF, 66'h0, 1'b1, 2'd0, 5'd10, 32'h0);
      run_one("hi_hs", 66'h0_1234_5678_0000_0000, 66'h0, 1'b0, 2'd1, 5'd11, 32'h12345678);
      run_one("hi_carry", 66'h0_0000_0001_0000_0000, 66'h0_0000_0000_8000_0000, 1'b0, 2'd2,
              5'd12, 32'h00000002);
      run_one("op3_lo", 66'h0_0000_0001_0000_00AB, 66'h0, 1'b0, 2'd3, 5'd13, 32'h000000AB);
      run_one("c_top_drop", 66'h3, 66'h2_0000_0000_0000_0000, 1'b0, 2'd0, 5'd14, 32'h00000003);

      // Backpressure: out_ready low for cycles 0..3, then high.
      mon_en = 1'b1;
      k = 0;
      held_res = '0;
      held_tag = '0;
      for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
         logic acc;
         out_ready = (cyc >= 4);
         drive(bp_s[k], bp_c[k], 1'b0, 2'd0, bp_tag[k]);
         @(negedge clk);
         if (cyc == 2 || cyc == 3) check($sformatf("bp_in_ready_c%0d", cyc), 66'(in_ready), 66'd0);
         if (cyc == 2) begin
            held_res = out_result;
            held_tag = out_tag;
            check("bp_first_vld", 66'(out_valid), 66'd1);
         end
         if (cyc == 3) begin
            check("bp_hold_vld", 66'(out_valid), 66'd1);
            check("bp_hold_res", 66'(out_result), 66'(held_res));
            check("bp_hold_tag", 66'(out_tag), 66'(held_tag));
         end
         acc = in_ready;
         next_cycle();
         if (acc) k++;
      end
      in_valid = 1'b0;
      for (int w = 0; w < 12 && got_res.size() < 4; w++) next_cycle();
      next_cycle();
      mon_en = 1'b0;
      check("bp_count", 66'(got_res.size()), 66'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_res.size()) begin
            check($sformatf("bp_res%0d", i), 66'(got_res[i]), 66'(bp_exp[i]));
            check($sformatf("bp_tag%0d", i), 66'(got_tag[i]), 66'(bp_tag[i]));
         end
      end

      // Flush with A in p2, B in p1 and C being accepted in the flush cycle.
      out_ready = 1'b1;
      drive(66'hA1, 66'h0, 1'b0, 2'd0, 5'd21);
      next_cycle();
      drive(66'hB2, 66'h0, 1'b0, 2'd0, 5'd22);
      next_cycle();
      drive(66'hC3, 66'h0, 1'b0, 2'd0, 5'd23);
      flush = 1'b1;
      @(negedge clk);
      check("fl_in_ready", 66'(in_ready), 66'd1);
      next_cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("fl_next_vld", 66'(out_valid), 66'd0);
      seen_valid = 0;
      for (int w = 0; w < 4; w++) begin
         next_cycle();
         @(negedge clk);
         if (out_valid) seen_valid++;
      end
      check("fl_no_output", 66'(seen_valid), 66'd0);
      next_cycle();
      run_one("fl_d", 66'hD4, 66'h1, 1'b1, 2'd0, 5'd24, 32'h000000D7);

      // Reset with both stages holding valid data.
      out_ready = 1'b0;
      drive(66'h55, 66'h0, 1'b0, 2'd0, 5'd25);
      next_cycle();
      drive(66'h66, 66'h0, 1'b0, 2'd0, 5'd26);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("mr_pre_vld", 66'(out_valid), 66'd1);
      check("mr_pre_res", 66'(out_result), 66'h55);
      check("mr_pre_rdy", 66'(in_ready), 66'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("mr_vld", 66'(out_valid), 66'd0);
      check("mr_res", 66'(out_result), 66'd0);
      check("mr_tag", 66'(out_tag), 66'd0);
      check("mr_rdy", 66'(in_ready), 66'd1);
      next_cycle();
      seen_valid = 0;
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         if (out_valid) seen_valid++;
         next_cycle();
      end
      check("mr_no_stale", 66'(seen_valid), 66'd0);
      out_ready = 1'b1;
      run_one("mr_after", 66'h0_0000_0002_0000_0000, 66'h0_0000_0001_0000_0000, 1'b0, 2'd1,
              5'd27, 32'h00000004);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
